// File: rtl/datapath_pkg.sv
// Shared datapath constants and the register dump state encoding.
// Imported by the register-file dump reader.
package datapath_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks r0..r(NUM_REGS-1) through a register-file read port and streams
// each value out over valid/ready, forwarding a same-cycle write.
module regfile_dump_reader
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] ReadRegister,
    input  logic [DATA_W-1:0] ReadData,
    input  logic              SnoopWrite,
    input  logic [ADDR_W-1:0] SnoopWriteRegister,
    input  logic [DATA_W-1:0] SnoopWriteData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W-1:0] OutIndex,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] fwdData;
    logic              snoopHit;

    // idx returns to 0 when idle, so the read address is 0 outside a dump
    assign ReadRegister = idx;

    // Same-cycle write to the fetched register wins over the stale read
    always_comb begin
        snoopHit = SnoopWrite && (SnoopWriteRegister == idx);
        fwdData  = snoopHit ? SnoopWriteData : ReadData;
    end

    // Dump sequencer with registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            OutValid <= 1'b0;
            OutData  <= '0;
            OutIndex <= '0;
            OutLast  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        state <= FETCH;
                        idx   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    OutData  <= fwdData;
                    OutIndex <= idx;
                    OutLast  <= (idx == LastIdx);
                    OutValid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        if (OutLast) begin
                            state <= IDLE;
                            idx   <= '0;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench for regfile_dump_reader with a behavioural
// register file and an expected-word table per dump.
module tb_regfile_dump_reader;
    import datapath_pkg::*;

    logic              clk;
    logic              reset;
    logic              Start;
    logic [ADDR_W-1:0] ReadRegister;
    logic [DATA_W-1:0] ReadData;
    logic              SnoopWrite;
    logic [ADDR_W-1:0] SnoopWriteRegister;
    logic [DATA_W-1:0] SnoopWriteData;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutData;
    logic [ADDR_W-1:0] OutIndex;
    logic              OutLast;
    logic              Busy;
    logic              Done;

    regfile_dump_reader dut (
        .clk                (clk),
        .reset              (reset),
        .Start              (Start),
        .ReadRegister       (ReadRegister),
        .ReadData           (ReadData),
        .SnoopWrite         (SnoopWrite),
        .SnoopWriteRegister (SnoopWriteRegister),
        .SnoopWriteData     (SnoopWriteData),
        .OutValid           (OutValid),
        .OutReady           (OutReady),
        .OutData            (OutData),
        .OutIndex           (OutIndex),
        .OutLast            (OutLast),
        .Busy               (Busy),
        .Done               (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] rf      [NUM_REGS];
    logic [DATA_W-1:0] loadVal [NUM_REGS];
    logic [DATA_W-1:0] expWord [NUM_REGS];
    logic              loadReq;

    assign ReadData = rf[ReadRegister];

    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= loadVal[i];
        end else if (SnoopWrite) begin
            rf[SnoopWriteRegister] <= SnoopWriteData;
        end
    end

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < NUM_REGS; i++) begin
            loadVal[i] = rnd ? $urandom : (32'h1000_0000 + 32'(i));
            expWord[i] = loadVal[i];
        end
        loadReq = 1'b1;
        step();
        loadReq = 1'b0;
    endtask

    task automatic startPulse();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // Cycle c counts from 1 = first cycle after the Start edge.
    task automatic collect(input int pct, input int wCyc,
                           input logic [ADDR_W-1:0] wReg,
                           input logic [DATA_W-1:0] wData,
                           input bit reStart);
        int n;
        int c;
        bit holdPrev;
        logic [DATA_W-1:0] hd;
        logic [ADDR_W-1:0] hi;
        n = 0;
        c = 1;
        holdPrev = 1'b0;
        hd = '0;
        hi = '0;
        while (n < NUM_REGS && c < 600) begin
            SnoopWrite         = (c == wCyc);
            SnoopWriteRegister = wReg;
            SnoopWriteData     = wData;
            Start    = reStart && (c == 10 || c == 64);
            OutReady = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            chk("busy", 32'(Busy), 32'd1);
            chk("no_done", 32'(Done), 32'd0);
            if (holdPrev) begin
                chk("hold_valid", 32'(OutValid), 32'd1);
                chk("hold_data", OutData, hd);
                chk("hold_idx", 32'(OutIndex), 32'(hi));
            end
            if (OutValid) begin
                chk("last_flag", 32'(OutLast),
                    32'(OutIndex == ADDR_W'(NUM_REGS - 1)));
                if (pct >= 100 && n == 0) chk("first_lat", 32'(c), 32'd2);
            end
            holdPrev = OutValid && !OutReady;
            hd = OutData;
            hi = OutIndex;
            if (OutValid && OutReady) begin
                chk("word_idx", 32'(OutIndex), 32'(n));
                chk("word_data", OutData, expWord[n]);
                if (pct >= 100 && n == NUM_REGS - 1)
                    chk("last_lat", 32'(c), 32'd64);
                n++;
            end
            step();
            c++;
        end
        if (n < NUM_REGS) chk("timeout_words", 32'(n), 32'(NUM_REGS));
        SnoopWrite = 1'b0;
        Start      = 1'b0;
        OutReady   = 1'b0;
        chk("done_pulse", 32'(Done), 32'd1);
        chk("busy_end", 32'(Busy), 32'd0);
        chk("valid_end", 32'(OutValid), 32'd0);
        step();
        chk("done_once", 32'(Done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("stay_idle", 32'(Busy), 32'd0);
            chk("idle_raddr", 32'(ReadRegister), 32'd0);
            step();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        Start = 1'b1;
        OutReady = 1'b1;
        SnoopWrite = 1'b0;
        SnoopWriteRegister = '0;
        SnoopWriteData = '0;
        loadReq = 1'b0;
        preload(1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("rst_valid", 32'(OutValid), 32'd0);
            chk("rst_data", OutData, 32'd0);
            chk("rst_idx", 32'(OutIndex), 32'd0);
            chk("rst_last", 32'(OutLast), 32'd0);
            chk("rst_busy", 32'(Busy), 32'd0);
            chk("rst_done", 32'(Done), 32'd0);
            chk("rst_raddr", 32'(ReadRegister), 32'd0);
            step();
        end
        reset = 1'b0;
        Start = 1'b0;
        OutReady = 1'b0;
        step();
        chk("post_rst_busy", 32'(Busy), 32'd0);

        preload(1'b0);
        startPulse();
        collect(100, -1, '0, '0, 1'b1);

        preload(1'b1);
        startPulse();
        collect(50, -1, '0, '0, 1'b0);

        preload(1'b0);
        expWord[5] = 32'hDEAD_BEEF;
        startPulse();
        collect(100, 11, ADDR_W'(5), 32'hDEAD_BEEF, 1'b0);

        preload(1'b0);
        startPulse();
        collect(100, 12, ADDR_W'(5), 32'hCAFE_F00D, 1'b0);

        preload(1'b0);
        expWord[0] = 32'h0BAD_0000;
        startPulse();
        collect(100, 1, ADDR_W'(0), 32'h0BAD_0000, 1'b0);

        preload(1'b0);
        startPulse();
        OutReady = 1'b1;
        for (int c = 1; c < 26; c++) step();
        chk("pre_abort_valid", 32'(OutValid), 32'd1);
        chk("pre_abort_idx", 32'(OutIndex), 32'd12);
        reset = 1'b1;
        OutReady = 1'b0;
        step();
        reset = 1'b0;
        chk("abort_valid", 32'(OutValid), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_raddr", 32'(ReadRegister), 32'd0);
        step();
        chk("abort_done2", 32'(Done), 32'd0);
        chk("abort_busy2", 32'(Busy), 32'd0);

        startPulse();
        collect(50, -1, '0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
